// File: rtl/host_bus_arbiter_if.sv
// host_bus_arbiter_if: command/status bundle between the arbiter and the AXI master host bus
//   master modport (arbiter side): drives m_size/m_addr/m_wdata/m_rw/m_clear, samples m_wait/m_done/m_error/m_invalid/m_rdata
//   slave modport (host bus side): the mirror image
interface host_bus_arbiter_if;
   logic [2:0]  m_size;
   logic [31:0] m_addr;
   logic [63:0] m_wdata;
   logic [1:0]  m_rw;
   logic        m_clear;
   logic        m_wait;
   logic        m_done;
   logic        m_error;
   logic        m_invalid;
   logic [63:0] m_rdata;
   modport master (output m_size, m_addr, m_wdata, m_rw, m_clear,
                   input  m_wait, m_done, m_error, m_invalid, m_rdata);
   modport slave  (input  m_size, m_addr, m_wdata, m_rw, m_clear,
                   output m_wait, m_done, m_error, m_invalid, m_rdata);
endinterface

// File: rtl/host_bus_arbiter.sv
// host_bus_arbiter: round-robin arbiter funnelling N_REQ requesters onto one AXI master host bus, one command at a time
//   i_clk/i_rst_n: clock, async active-low reset
//   i_req_*: per-requester valid/rw/size/addr/wdata; o_req_ready/o_req_done: one-hot accept/completion pulses
//   o_req_error/o_req_invalid: status alongside o_req_done; o_rdata: last read data; o_busy: not idle
//   bus: command/status to the host bus
module host_bus_arbiter #(
   parameter int N_REQ = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [N_REQ-1:0]      i_req_valid,
   input  logic [2*N_REQ-1:0]    i_req_rw,
   input  logic [3*N_REQ-1:0]    i_req_size,
   input  logic [32*N_REQ-1:0]   i_req_addr,
   input  logic [64*N_REQ-1:0]   i_req_wdata,
   output logic [N_REQ-1:0]      o_req_ready,
   output logic [N_REQ-1:0]      o_req_done,
   output logic                  o_req_error,
   output logic                  o_req_invalid,
   output logic [63:0]           o_rdata,
   output logic                  o_busy,
   host_bus_arbiter_if.master    bus
);
   localparam int IW = (N_REQ > 2) ? 2 : 1;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_CLEAR = 2'd3;
   logic [1:0]    state;
   logic [IW-1:0] r_last, r_gnt, gnt_idx;
   logic [IW:0]   cand;
   logic          gnt_any;
   logic [1:0]    r_rw, g_rw;
   logic [2:0]    r_size, g_size;
   logic [31:0]   r_addr, g_addr;
   logic [63:0]   r_wdata, g_wdata;
   logic          r_err, r_inv;
   logic          rw_ok, m_fin;
   // Scan from farthest to nearest so the requester closest after r_last wins.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         cand = {1'b0, r_last} + (IW+1)'(k);
         cand = (cand >= (IW+1)'(N_REQ)) ? cand - (IW+1)'(N_REQ) : cand;
         if (i_req_valid[cand[IW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = cand[IW-1:0];
         end
      end
   end
   always_comb begin
      g_rw    = '0;
      g_size  = '0;
      g_addr  = '0;
      g_wdata = '0;
      for (int i = 0; i < N_REQ; i++)
         if (gnt_idx == IW'(i)) begin
            g_rw    = i_req_rw[2*i +: 2];
            g_size  = i_req_size[3*i +: 3];
            g_addr  = i_req_addr[32*i +: 32];
            g_wdata = i_req_wdata[64*i +: 64];
         end
   end
   assign rw_ok         = r_rw[1] ^ r_rw[0];
   assign m_fin         = ~bus.m_wait & bus.m_done;
   // Ready is gated by reset so a held valid cannot leak an accept while in reset.
   assign o_req_ready   = (i_rst_n && state == S_IDLE && gnt_any) ? N_REQ'(1) << gnt_idx : '0;
   assign o_req_done    = (state == S_CLEAR) ? N_REQ'(1) << r_gnt : '0;
   assign o_req_error   = (state == S_CLEAR) & r_err;
   assign o_req_invalid = (state == S_CLEAR) & r_inv;
   assign o_busy        = state != S_IDLE;
   assign bus.m_rw      = (state == S_ISSUE && rw_ok) ? r_rw : 2'b00;
   assign bus.m_clear   = state == S_CLEAR;
   assign bus.m_size    = r_size;
   assign bus.m_addr    = r_addr;
   assign bus.m_wdata   = r_wdata;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state   <= S_IDLE;
         r_last  <= IW'(N_REQ-1);
         r_gnt   <= '0;
         r_rw    <= '0;
         r_size  <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_err   <= 1'b0;
         r_inv   <= 1'b0;
         o_rdata <= '0;
      end else
         case (state)
            S_IDLE:
               if (gnt_any) begin
                  r_gnt   <= gnt_idx;
                  r_last  <= gnt_idx;
                  r_rw    <= g_rw;
                  r_size  <= g_size;
                  r_addr  <= g_addr;
                  r_wdata <= g_wdata;
                  state   <= S_ISSUE;
               end
            S_ISSUE, S_WAIT:
               if (state == S_ISSUE && !rw_ok) begin
                  r_err <= 1'b1;
                  r_inv <= 1'b1;
                  state <= S_CLEAR;
               end else if (m_fin) begin
                  r_err   <= bus.m_error;
                  r_inv   <= bus.m_invalid;
                  o_rdata <= (r_rw == 2'b10) ? bus.m_rdata : o_rdata;
                  state   <= S_CLEAR;
               end else if (bus.m_wait)
                  state <= S_WAIT;
            default:
               state <= S_IDLE;
         endcase
endmodule

// File: tb/tb_host_bus_arbiter.sv
// tb_host_bus_arbiter: table-driven scoreboard bench for host_bus_arbiter
module tb_host_bus_arbiter;
   localparam int N = 2;
   logic           i_clk = 1'b0;
   logic           i_rst_n = 1'b0;
   logic [N-1:0]   valid = '0;
   logic [2*N-1:0] rw = '0;
   logic [3*N-1:0] size = '0;
   logic [32*N-1:0] addr = '0;
   logic [64*N-1:0] wdata = '0;
   logic [N-1:0]   ready, done;
   logic           err, inv, busy;
   logic [63:0]    rdata;
   int             total = 0;
   int             bad = 0;
   int             cyc = 0;
   host_bus_arbiter_if bus();
   host_bus_arbiter #(.N_REQ(N)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_req_valid(valid), .i_req_rw(rw), .i_req_size(size), .i_req_addr(addr), .i_req_wdata(wdata),
      .o_req_ready(ready), .o_req_done(done), .o_req_error(err), .o_req_invalid(inv),
      .o_rdata(rdata), .o_busy(busy), .bus(bus.master));
   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc++;
   typedef struct {
      logic [N-1:0] vmask; int g; logic [1:0] rw; logic [2:0] sz; logic [31:0] addr; logic [63:0] wd;
      int wt; logic merr; logic minv; logic [63:0] mrd; logic xerr; logic xinv; logic [63:0] xrd;
   } vec_t;
   typedef struct { logic [N-1:0] done; logic e; logic i; logic [63:0] rd; int lat; } exp_t;
   vec_t vt[10];
   exp_t sb[$];
   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask
   task automatic bus_idle();
      bus.m_wait = 1'b0; bus.m_done = 1'b0; bus.m_error = 1'b0; bus.m_invalid = 1'b0; bus.m_rdata = '0;
   endtask
   always @(negedge i_clk)
      if (i_rst_n) chk("onehot", {62'b0, $onehot0(ready), $onehot0(done)}, 64'h3);
   task automatic do_vec(vec_t v);
      int t0, g;
      logic ok;
      exp_t e, a;
      ok = (v.rw == 2'b01) || (v.rw == 2'b10);
      for (int i = 0; i < N; i++) begin
         rw[2*i +: 2]     = (i == v.g) ? v.rw : 2'b01;
         size[3*i +: 3]   = (i == v.g) ? v.sz : 3'd2;
         addr[32*i +: 32] = (i == v.g) ? v.addr : ~v.addr;
         wdata[64*i +: 64] = (i == v.g) ? v.wd : ~v.wd;
      end
      valid = v.vmask;
      g = 0;
      do begin @(negedge i_clk); g++; end while (ready == '0 && g < 10);
      chk("ready", 64'(ready), 64'(N'(1) << v.g));
      t0 = cyc;
      e.done = N'(1) << v.g; e.e = v.xerr; e.i = v.xinv; e.rd = v.xrd;
      e.lat = (ok && v.wt > 0) ? 2 + v.wt : 2;
      sb.push_back(e);
      @(posedge i_clk); #1;
      valid = '0;
      if (ok && v.wt == 0) begin
         bus.m_done = 1'b1; bus.m_error = v.merr; bus.m_invalid = v.minv; bus.m_rdata = v.mrd;
      end else if (ok) bus.m_wait = 1'b1;
      @(negedge i_clk);
      chk("issue_rw", 64'(bus.m_rw), 64'(ok ? v.rw : 2'b00));
      chk("issue_addr", 64'(bus.m_addr), 64'(v.addr));
      chk("issue_size", 64'(bus.m_size), 64'(v.sz));
      chk("issue_wdata", bus.m_wdata, v.wd);
      chk("issue_busy", 64'(busy), 64'd1);
      if (ok)
         for (int j = 1; j <= v.wt; j++) begin
            @(negedge i_clk);
            chk("wait_rw", 64'(bus.m_rw), 64'd0);
            if (j == v.wt) begin
               bus.m_wait = 1'b0; bus.m_done = 1'b1; bus.m_error = v.merr; bus.m_invalid = v.minv; bus.m_rdata = v.mrd;
            end
         end
      g = 0;
      do begin @(negedge i_clk); g++; end while (done == '0 && g < 20);
      bus_idle();
      a = sb.pop_front();
      chk("done", 64'(done), 64'(a.done));
      chk("err", 64'(err), 64'(a.e));
      chk("inv", 64'(inv), 64'(a.i));
      chk("rdata", rdata, a.rd);
      chk("latency", 64'(cyc - t0), 64'(a.lat));
      chk("clear", 64'(bus.m_clear), 64'd1);
      chk("clear_rw", 64'(bus.m_rw), 64'd0);
   endtask
   initial begin
      int g;
      bus_idle();
      vt[0] = '{2'b11, 0, 2'b10, 3'd2, 32'h100, 64'h0, 1, 1'b0, 1'b0, 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0, 64'hDEAD_BEEF};
      vt[1] = '{2'b11, 1, 2'b01, 3'd2, 32'h200, 64'h1111_2222_3333_4444, 2, 1'b0, 1'b0, 64'h5555, 1'b0, 1'b0, 64'hDEAD_BEEF};
      vt[2] = '{2'b11, 0, 2'b01, 3'd3, 32'h308, 64'hA5A5, 0, 1'b0, 1'b0, 64'h77, 1'b0, 1'b0, 64'hDEAD_BEEF};
      vt[3] = '{2'b11, 1, 2'b01, 3'd0, 32'h401, 64'h5A, 1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'hDEAD_BEEF};
      vt[4] = '{2'b10, 1, 2'b01, 3'd1, 32'h101, 64'hBEEF, 0, 1'b1, 1'b1, 64'h0, 1'b1, 1'b1, 64'hDEAD_BEEF};
      vt[5] = '{2'b01, 0, 2'b11, 3'd2, 32'h40, 64'h0, 0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 64'hDEAD_BEEF};
      vt[6] = '{2'b11, 1, 2'b10, 3'd3, 32'h8, 64'h0, 1, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF};
      vt[7] = '{2'b01, 0, 2'b10, 3'd2, 32'h10, 64'h0, 3, 1'b1, 1'b0, 64'hCAFE, 1'b1, 1'b0, 64'hCAFE};
      vt[8] = '{2'b10, 1, 2'b00, 3'd0, 32'h20, 64'h9, 0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 64'hCAFE};
      vt[9] = '{2'b11, 0, 2'b01, 3'd2, 32'h30, 64'h42, 0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'hCAFE};
      valid = 2'b11;
      #12;
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_rdata", rdata, 64'd0);
      chk("rst_mrw", 64'(bus.m_rw), 64'd0);
      chk("rst_addr", 64'(bus.m_addr), 64'd0);
      valid = '0;
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      for (int i = 0; i < 10; i++) do_vec(vt[i]);
      rw = 4'b0110; size = '0; addr = {32'h500, 32'h600}; wdata = '0;
      valid = 2'b10;
      g = 0;
      do begin @(negedge i_clk); g++; end while (ready == '0 && g < 10);
      chk("mid_ready", 64'(ready), 64'b10);
      @(posedge i_clk); #1;
      valid = '0;
      bus.m_wait = 1'b1;
      @(posedge i_clk); #1;
      chk("mid_busy", 64'(busy), 64'd1);
      valid = 2'b11;
      i_rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_ready", 64'(ready), 64'd0);
      chk("mid_rst_rdata", rdata, 64'd0);
      chk("mid_rst_addr", 64'(bus.m_addr), 64'd0);
      chk("mid_rst_clear", 64'(bus.m_clear), 64'd0);
      chk("mid_rst_err", 64'(err), 64'd0);
      bus_idle();
      @(posedge i_clk); #1;
      chk("mid_rst_nodone", 64'(done), 64'd0);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      chk("post_rst_ready", 64'(ready), 64'b01);
      @(posedge i_clk); #1;
      valid = '0;
      bus.m_done = 1'b1;
      g = 0;
      do begin @(negedge i_clk); g++; end while (done == '0 && g < 10);
      bus_idle();
      chk("post_rst_done", 64'(done), 64'b01);
      chk("post_rst_err", 64'(err), 64'd0);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      @(negedge i_clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/host_bus_arbiter.md
HOST_BUS_ARBITER -- requirements
Module: host_bus_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of requesters (legal 2..4).
REQ-002 SHALL have i_clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have i_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have i_req_valid  in  N_REQ  per-requester command valid.
REQ-005 SHALL have i_req_rw  in  2*N_REQ  per-requester op: 01 write, 10 read, 00/11 see REQ-021.
REQ-006 SHALL have i_req_size  in  3*N_REQ  per-requester size: 0 byte, 1 half, 2 word, 3 dword.
REQ-007 SHALL have i_req_addr  in  32*N_REQ  per-requester address.
REQ-008 SHALL have i_req_wdata  in  64*N_REQ  per-requester write data.
REQ-009 SHALL have o_req_ready  out  N_REQ  one-hot accept pulse.
REQ-010 SHALL have o_req_done  out  N_REQ  one-hot completion pulse.
REQ-011 SHALL have o_req_error, o_req_invalid  out  1 each  status, valid with any o_req_done bit.
REQ-012 SHALL have o_rdata  out  64  last read data, held until the next completion.
REQ-013 SHALL have o_busy  out  1  high in every state except S_IDLE.
REQ-014 SHALL have m_size 3, m_addr 32, m_wdata 64, m_rw 2, m_clear 1  out  command to the AXI master host bus.
REQ-015 SHALL have i_m_wait, i_m_done, i_m_error, i_m_invalid 1 each, i_m_rdata 64  in  status from the AXI master host bus.

Function
REQ-016 SHALL implement states S_IDLE, S_ISSUE, S_WAIT, S_CLEAR.
REQ-017 S_IDLE: SHALL grant, combinationally, the first valid requester searching round-robin from r_last+1 mod N_REQ; SHALL assert o_req_ready for the grantee in that cycle only; SHALL register the grantee's rw/size/addr/wdata and grant index; SHALL set r_last to the grantee; next state S_ISSUE.
REQ-018 Requesters SHALL hold valid and command stable until ready; after ready, valid may drop or present a new command.
REQ-019 S_ISSUE: SHALL drive m_rw from the registered rw, with m_size/m_addr/m_wdata from registers. Transitions:
- i_m_wait=1 -> S_WAIT.
- i_m_wait=0 and i_m_done=1 (immediate reject, e.g. misaligned) -> capture status -> S_CLEAR.
- Neither -> stay and keep driving.
REQ-020 m_rw SHALL be 00 in every state except S_ISSUE; m_size/m_addr/m_wdata SHALL hold their registered values.
REQ-021 A granted rw of 00 or 11 SHALL not be issued; next state S_CLEAR with captured error=1, invalid=1, rdata unchanged.
REQ-022 S_WAIT: on i_m_wait=0 and i_m_done=1, SHALL capture i_m_error, i_m_invalid and, for reads, i_m_rdata into o_rdata, then go to S_CLEAR; otherwise stay, no timeout.
REQ-023 S_CLEAR: SHALL assert m_clear=1 for exactly one cycle with m_rw=00; SHALL assert o_req_done[grantee] with captured status that same cycle; next state S_IDLE.
REQ-024 Completion latency: o_req_done SHALL rise exactly one cycle after the master-completion cycle; minimum ready-to-done is 2 cycles (reject in S_ISSUE).
REQ-025 A completed write SHALL leave o_rdata unchanged.
REQ-026 Arbitration SHALL occur only in S_IDLE; valid changes in other states SHALL have no effect; at most one outstanding command.
REQ-027 With all valid high, grants SHALL rotate 0,1,..,N_REQ-1,0; each requester SHALL be granted within N_REQ commands.
REQ-028 Multiple o_req_ready or o_req_done bits SHALL never be high simultaneously.

Reset
REQ-029 i_rst_n=0 SHALL immediately set:
- state S_IDLE, r_last=N_REQ-1 (requester 0 wins first).
- o_req_ready, o_req_done, o_req_error, o_req_invalid, o_busy, m_rw, m_clear = 0.
- o_rdata, m_size, m_addr, m_wdata = 0.
REQ-030 Reset mid-transfer SHALL abandon it without a done pulse; the AXI master SHALL be reset in the same cycle by the integrator.
REQ-031 First grant SHALL be possible in the first cycle after i_rst_n deasserts.

Verification
REQ-032 Req0 read addr 0x100 size 2, master returns 0x0000_0000_DEAD_BEEF okay -> ready0 cycle 0, m_rw=10 cycle 1 only, done0 with error=0, o_rdata=0xDEADBEEF, m_clear one cycle.
REQ-033 Both valid continuously, 4 writes -> grant order 0,1,0,1; one done per ready, never overlapping.
REQ-034 Req1 half write addr 0x101, master rejects immediately (done=1, error=1, invalid=1, wait=0) -> done1 next cycle, error=1, invalid=1, m_clear=1, total 3 cycles.
REQ-035 Req0 rw=11 -> no m_rw activity, done0 at cycle 2, error=1, invalid=1, o_rdata unchanged.
REQ-036 i_rst_n low while in S_WAIT -> all outputs 0 same cycle; after release, req0 is granted first.
